// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//
// This block adds two WIDTH-bit operands through a single one-bit full-adder
// cell. It processes one bit per clock, starting with the LSB. It owns the
// operand shift registers, the carry flop, the bit counter, the result shift
// register and the start/done handshake.
//
// Timing:
//   - An accepted start at edge E0 loads the operands and enters RUN.
//   - Edges E1..E_WIDTH each resolve one bit.
//   - done is high for the single cycle that follows E_WIDTH.
//
// Optional feature:
//   - Defining SERIAL_ADD_OVF_EN adds the ovf output, which reports signed
//     two's-complement overflow.
//   - Without that macro the port and its logic are absent.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous reset, active-low
//   start  in   1      request pulse, sampled only in IDLE
//   a      in   WIDTH  operand A, captured on accepted start
//   b      in   WIDTH  operand B, captured on accepted start
//   cin    in   1      carry-in, captured on accepted start
//   busy   out  1      high while an addition is in progress
//   done   out  1      one-cycle pulse, result valid
//   sum    out  WIDTH  result, held until the next accepted start
//   cout   out  1      final carry-out, held with sum
//   ovf    out  1      signed overflow (SERIAL_ADD_OVF_EN only)
// ---------------------------------------------------------------------------
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_sr;
    logic             cout_r;
    logic             done_r;

    // Control strobes from the output decoder
    logic             load;
    logic             step;
    logic             last_bit;

    // The shared one-bit adder cell
    logic             fa_s;
    logic             fa_c;

    function automatic logic fa_sum(input logic x, input logic y, input logic ci);
        return x ^ y ^ ci;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic ci);
        return (x & y) | (x & ci) | (y & ci);
    endfunction

    assign fa_s     = fa_sum(op_a[0], op_b[0], carry);
    assign fa_c     = fa_carry(op_a[0], op_b[0], carry);
    assign last_bit = (cnt == LAST_BIT);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)    state_next = RUN;
            RUN:     if (last_bit) state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // ---------------- output / strobe decode ----------------
    always_comb begin
        busy = 1'b0;
        load = 1'b0;
        step = 1'b0;
        case (state)
            IDLE: begin
                load = start;
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ---------------- datapath ----------------
    // The result register is not cleared on load. Previous result bits stay
    // visible until the first RUN edge starts shifting the new bits in.
    // This register shifts right and the new bit enters at the MSB, so after
    // WIDTH shifts the first (LSB) bit has reached position 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_sr <= '0;
            cout_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (load) begin
                op_a  <= a;
                op_b  <= b;
                carry <= cin;
                cnt   <= '0;
            end else if (step) begin
                op_a   <= op_a >> 1;
                op_b   <= op_b >> 1;
                sum_sr <= (sum_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                carry  <= fa_c;
                cnt    <= cnt + CNT_W'(1);
                if (last_bit) begin
                    cout_r <= fa_c;
                    done_r <= 1'b1;
                end
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_r;

    // At the last bit, the carry register holds the carry into the MSB and
    // fa_c is the carry out of the MSB. Their XOR is signed overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (load) begin
            ovf_r <= 1'b0;
        end else if (step && last_bit) begin
            ovf_r <= carry ^ fa_c;
        end
    end

    assign ovf = ovf_r;
`endif

    assign sum  = sum_sr;
    assign cout = cout_r;
    assign done = done_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Self-checking bench for serial_add_ctrl with WIDTH=8. It is built from
// three parts:
//   - a table of directed vectors;
//   - hand-written sequences for the multi-cycle corner cases: an ignored
//     start while busy, a reset in mid-run, and back-to-back starts;
//   - randomized operands checked against an arithmetic reference model.
//
// Define SERIAL_ADD_OVF_EN to include the ovf port and its checks.
// ---------------------------------------------------------------------------
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cin_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef SERIAL_ADD_OVF_EN
    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a_in), .b(b_in), .cin(cin_in),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );
`else
    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a_in), .b(b_in), .cin(cin_in),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );
    assign ovf = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // The reference model treats the operands as plain integers.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                                  output logic [W-1:0] s, output logic co, output logic ov);
        int u;
        int sv;
        u  = int'(x) + int'(y) + int'(c);
        s  = W'(u % (1 << W));
        co = (u >= (1 << W));
        sv = int'($signed(x)) + int'($signed(y)) + int'(c);
        ov = (sv > (1 << (W - 1)) - 1) || (sv < -(1 << (W - 1)));
    endfunction

    // Presents start during the current cycle, then runs until done.
    // lat is the number of edges from the start edge to done.
    // bcnt is the number of cycles in which busy was seen high.
    // The operand inputs are scrambled during RUN, and this must have no
    // effect on the result.
    task automatic run_add(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                           output logic [W-1:0] s, output logic co, output logic ov,
                           output int lat, output int bcnt);
        a_in = ia; b_in = ib; cin_in = icin; start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        a_in   = W'($urandom);
        b_in   = W'($urandom);
        cin_in = 1'($urandom);
        bcnt = busy ? 1 : 0;
        lat  = 0;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
            if (busy) bcnt++;
            if (lat >= 40) begin
                $display("FAIL run_add timeout: no done within %0d edges", lat);
                break;
            end
        end
        s = sum; co = cout; ov = ovf;
    endtask

    vec_t         tbl[6];
    logic [W-1:0] s, es;
    logic         co, ov, eco, eov;
    int           lat, bcnt, dcnt, dedge;

    initial begin
        tbl[0] = '{a:8'h3C, b:8'h0F, cin:1'b0, s:8'h4B, co:1'b0, ov:1'b0};
        tbl[1] = '{a:8'hFF, b:8'h01, cin:1'b0, s:8'h00, co:1'b1, ov:1'b0};
        tbl[2] = '{a:8'hFF, b:8'hFF, cin:1'b1, s:8'hFF, co:1'b1, ov:1'b0};
        tbl[3] = '{a:8'h7F, b:8'h01, cin:1'b0, s:8'h80, co:1'b0, ov:1'b1};
        tbl[4] = '{a:8'h80, b:8'h80, cin:1'b0, s:8'h00, co:1'b1, ov:1'b1};
        tbl[5] = '{a:8'h00, b:8'h00, cin:1'b1, s:8'h01, co:1'b0, ov:1'b0};

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum",  32'(sum),  32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_ovf",  32'(ovf),  32'd0);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            run_add(tbl[i].a, tbl[i].b, tbl[i].cin, s, co, ov, lat, bcnt);
            check($sformatf("tbl%0d_sum", i),  32'(s),    32'(tbl[i].s));
            check($sformatf("tbl%0d_cout", i), 32'(co),   32'(tbl[i].co));
`ifdef SERIAL_ADD_OVF_EN
            check($sformatf("tbl%0d_ovf", i),  32'(ov),   32'(tbl[i].ov));
`endif
            check($sformatf("tbl%0d_lat", i),  32'(lat),  32'd8);
            check($sformatf("tbl%0d_busy", i), 32'(bcnt), 32'd8);
            check($sformatf("tbl%0d_busy_at_done", i), 32'(busy), 32'd0);
            @(posedge clk); #1;
            check($sformatf("tbl%0d_done_clr", i), 32'(done), 32'd0);
            check($sformatf("tbl%0d_hold", i),     32'(sum),  32'(tbl[i].s));
        end

        // A start while busy is ignored and produces a single done
        a_in = 8'h10; b_in = 8'h20; cin_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dcnt = 0; dedge = 0; s = '0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) begin
                start = 1'b1; a_in = 8'hAA; b_in = 8'h55;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                dcnt++;
                dedge = k;
                s = sum;
            end
        end
        check("ign_done_count", 32'(dcnt),  32'd1);
        check("ign_done_edge",  32'(dedge), 32'd8);
        check("ign_sum",        32'(s),     32'h30);

        // Reset in mid-run discards the partial result
        a_in = 8'h55; b_in = 8'h11; cin_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        dcnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check("rst_no_done", 32'(dcnt), 32'd0);
        run_add(8'h01, 8'h02, 1'b0, s, co, ov, lat, bcnt);
        check("post_rst_sum", 32'(s),   32'h03);
        check("post_rst_lat", 32'(lat), 32'd8);

        // Back-to-back: the second start is presented in the done cycle
        run_add(8'h3C, 8'h0F, 1'b0, s, co, ov, lat, bcnt);
        check("b2b_first_sum", 32'(s), 32'h4B);
        run_add(8'h05, 8'h06, 1'b0, s, co, ov, lat, bcnt);
        check("b2b_lat",  32'(lat), 32'd8);
        check("b2b_sum",  32'(s),   32'h0B);
        check("b2b_cout", 32'(co),  32'd0);

        // Randomized operands against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic         rc;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            model(ra, rb, rc, es, eco, eov);
            run_add(ra, rb, rc, s, co, ov, lat, bcnt);
            check($sformatf("rnd%0d_sum", i),  32'(s),   32'(es));
            check($sformatf("rnd%0d_cout", i), 32'(co),  32'(eco));
`ifdef SERIAL_ADD_OVF_EN
            check($sformatf("rnd%0d_ovf", i),  32'(ov),  32'(eov));
`endif
            check($sformatf("rnd%0d_lat", i),  32'(lat), 32'd8);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
